keccak_round_ctrl: RTL and testbench

Sequencer for the Keccak-f[1600] permutation datapath. It accepts a state-load request, steps the round index through all rounds, and drives the iota stage's 5-bit round input plus the state-register enables. It holds the result until the consumer takes it. It sits between the sponge absorb/squeeze logic and the theta/rho/pi/chi/iota round datapath and its state register.

---
 rtl/keccak_round_ctrl_if.sv | 30 +++
 rtl/keccak_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_keccak_round_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_round_ctrl_if
//  Brief    : Load/result handshake between the sponge logic and the
//             Keccak-f round sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface keccak_round_ctrl_if;
  logic in_valid;   // new state presented to the datapath input
  logic in_ready;   // sequencer can accept a state this cycle
  logic out_valid;  // permuted state valid in the state register
  logic out_ready;  // consumer takes the result

  // Sponge side: offers states and consumes results
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  // Sequencer side
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface
`default_nettype wire

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keccak_round_ctrl
//  Brief    : Round sequencer for Keccak-f[1600]. Loads a state, steps the
//             round index RPC rounds per clock, then holds the result until
//             the consumer takes it.
//  Revision : 1.0  initial release
// ============================================================================
module keccak_round_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int RPC        = 1,
  parameter int CNT_W      = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             abort,
  keccak_round_ctrl_if.slave    hs,
  output logic                  st_load,
  output logic                  st_round_en,
  output logic [4:0]            round_idx,
  output logic                  busy,
  output logic [CNT_W-1:0]      perm_cnt
);

  // Guarded modulo so an illegal RPC=0 cannot divide by zero at elaboration.
  localparam bit c_rpc_ok    = (RPC >= 1) &&
                               ((NUM_ROUNDS % ((RPC >= 1) ? RPC : 1)) == 0);
  localparam bit c_rounds_ok = (NUM_ROUNDS >= 1) && (NUM_ROUNDS <= 24);

  if (!c_rounds_ok) begin : g_bad_rounds
    $error("keccak_round_ctrl: NUM_ROUNDS must be within 1..24");
  end

  if (!c_rpc_ok) begin : g_bad_rpc
    $error("keccak_round_ctrl: NUM_ROUNDS must be a multiple of RPC");
  end

  localparam logic [4:0] c_rpc  = 5'(RPC);
  localparam logic [4:0] c_last = 5'(NUM_ROUNDS - RPC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_cnt;
  logic [4:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_perm_cnt;
  logic             w_perm_inc;

  logic             w_in_ready;
  logic             w_st_load;
  logic             w_round_en;
  logic             w_out_valid;
  logic             w_busy;
  logic [4:0]       w_round_idx;

  // Output decode and next-state selection; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_perm_inc  = 1'b0;
    w_round_en  = 1'b0;
    w_out_valid = 1'b0;
    w_round_idx = 5'd0;
    w_busy      = (r_state == RUN);
    // A held result can be replaced in the same cycle it is consumed.
    w_in_ready  = !abort && ((r_state == IDLE) ||
                             ((r_state == HOLD) && hs.out_ready));
    w_st_load   = hs.in_valid && w_in_ready;

    if (r_state == RUN) begin
      w_round_idx = r_cnt;
      w_round_en  = !abort;
    end
    if (r_state == HOLD) begin
      w_out_valid = !abort;
    end

    if (abort) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_st_load) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 5'd0;
          end
        end
        RUN: begin
          if (r_cnt == c_last) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = 5'd0;
            w_perm_inc  = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + c_rpc;
          end
        end
        HOLD: begin
          if (hs.out_ready) begin
            w_state_nxt = w_st_load ? RUN : IDLE;
            w_cnt_nxt   = 5'd0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 5'd0;
        end
      endcase
    end
  end

  // State, round counter and completed-permutation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 5'd0;
      r_perm_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_perm_inc) begin
        r_perm_cnt <= r_perm_cnt + CNT_W'(1);
      end
    end
  end

  assign hs.in_ready  = w_in_ready;
  assign hs.out_valid = w_out_valid;
  assign st_load      = w_st_load;
  assign st_round_en  = w_round_en;
  assign round_idx    = w_round_idx;
  assign busy         = w_busy;
  assign perm_cnt     = r_perm_cnt;

`ifndef SYNTHESIS
  // The state register has one write source per cycle.
  a_load_round_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_st_load && w_round_en));

  a_valid_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
    w_out_valid |-> (r_state == HOLD));

  a_valid_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (w_out_valid && !hs.out_ready) |=> (w_out_valid || abort));

  a_inputs_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({hs.in_valid, hs.out_ready}));
`endif

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keccak_round_ctrl
//  Brief    : Scoreboard bench for keccak_round_ctrl (RPC=1 and RPC=4 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_keccak_round_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic abort4 = 1'b0;

  always #5 clk = ~clk;

  keccak_round_ctrl_if hs ();
  keccak_round_ctrl_if hs4 ();

  logic        st_load, st_round_en, busy;
  logic [4:0]  round_idx;
  logic [15:0] perm_cnt;

  logic        st_load4, st_round_en4, busy4;
  logic [4:0]  round_idx4;
  logic [15:0] perm_cnt4;

  keccak_round_ctrl #(.NUM_ROUNDS(24), .RPC(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .hs(hs),
    .st_load(st_load), .st_round_en(st_round_en), .round_idx(round_idx),
    .busy(busy), .perm_cnt(perm_cnt)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(24), .RPC(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .abort(abort4), .hs(hs4),
    .st_load(st_load4), .st_round_en(st_round_en4), .round_idx(round_idx4),
    .busy(busy4), .perm_cnt(perm_cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_loads  = 0;
  int load_cyc[$];

  // One expected result per accepted load: perm_cnt at handoff, load-to-valid
  // latency in cycles, and cycles the result is held before being taken.
  typedef struct {
    int cnt;
    int lat;
    int hold;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle invariants plus scoreboard pop on each result handoff.
  initial begin
    int   t_load  = 0;
    int   t_first = 0;
    int   rounds  = 0;
    int   exp_idx = 0;
    logic prev_ov = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) check("in_ready_while_busy", hs.in_ready, 0);
        if (!busy) check("round_idx_not_run", round_idx, 0);
        if (hs.out_valid) check("round_en_in_hold", st_round_en, 0);
        if (st_round_en) begin
          check("round_idx_seq", round_idx, exp_idx);
          exp_idx++;
          rounds++;
        end
        if (hs.out_valid && !prev_ov) t_first = cyc;
        if (hs.out_valid && hs.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: actual=handoff required=none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("perm_cnt_at_handoff", perm_cnt, e.cnt);
            check("latency", t_first - t_load, e.lat);
            check("hold_cycles", cyc - t_first, e.hold);
            check("round_count", rounds, 24);
          end
        end
        if (st_load) begin
          t_load  = cyc;
          rounds  = 0;
          exp_idx = 0;
          n_loads++;
          load_cyc.push_back(cyc);
        end
        prev_ov = hs.out_valid;
      end else begin
        prev_ov = 1'b0;
      end
    end
  end

  task automatic pulse_load();
    @(posedge clk); #1 hs.in_valid = 1'b1;
    @(posedge clk); #1 hs.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !hs.out_valid) break;
    end
    check(name, (i == 300), 0);
  endtask

  task automatic wait_round(input logic [4:0] idx, input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && round_idx == idx) break;
    end
    check(name, (i == 100), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] idx4_tbl [6];
    int b;
    int i;
    idx4_tbl = '{5'd0, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20};
    hs.in_valid   = 1'b0;
    hs.out_ready  = 1'b1;
    hs4.in_valid  = 1'b0;
    hs4.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready", hs.in_ready, 1);
    check("rst_out_valid", hs.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_st_load", st_load, 0);
    check("rst_round_en", st_round_en, 0);
    check("rst_round_idx", round_idx, 0);
    check("rst_perm_cnt", perm_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single permutation, consumer always ready
    exp_q.push_back('{cnt: 1, lat: 25, hold: 0});
    pulse_load();
    wait_drain("single_drain");
    check("single_perm_cnt", perm_cnt, 1);

    // Back-to-back with in_valid and out_ready held high
    exp_q.push_back('{cnt: 2, lat: 25, hold: 0});
    exp_q.push_back('{cnt: 3, lat: 25, hold: 0});
    exp_q.push_back('{cnt: 4, lat: 25, hold: 0});
    b = n_loads;
    @(posedge clk); #1 hs.in_valid = 1'b1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (n_loads >= b + 3) break;
    end
    check("b2b_three_loads", (n_loads >= b + 3), 1);
    @(posedge clk); #1 hs.in_valid = 1'b0;
    if (load_cyc.size() >= b + 3) begin
      check("b2b_gap1", load_cyc[b+1] - load_cyc[b], 25);
      check("b2b_gap2", load_cyc[b+2] - load_cyc[b+1], 25);
    end
    wait_drain("b2b_drain");
    check("b2b_perm_cnt", perm_cnt, 4);

    // Backpressure: consumer stalls for 10 cycles after the result appears
    hs.out_ready = 1'b0;
    exp_q.push_back('{cnt: 5, lat: 25, hold: 10});
    pulse_load();
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hs.out_valid) break;
    end
    check("bp_valid_seen", hs.out_valid, 1);
    repeat (10) @(posedge clk);
    #1 hs.out_ready = 1'b1;
    wait_drain("bp_drain");

    // Abort mid-permutation at round 12
    pulse_load();
    wait_round(5'd12, "abort12_reach");
    #1 abort = 1'b1;
    #1;
    check("abort12_round_en", st_round_en, 0);
    check("abort12_out_valid", hs.out_valid, 0);
    check("abort12_in_ready", hs.in_ready, 0);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort12_busy", busy, 0);
    check("abort12_idle_ready", hs.in_ready, 1);
    check("abort12_perm_cnt", perm_cnt, 5);

    // Abort on the last round: no HOLD and no count
    pulse_load();
    wait_round(5'd23, "abort23_reach");
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort23_no_valid", hs.out_valid, 0);
    end
    check("abort23_perm_cnt", perm_cnt, 5);

    // Asynchronous reset in the middle of a permutation
    pulse_load();
    wait_round(5'd7, "rst7_reach");
    #1 rst_n = 1'b0;
    #1;
    check("rst7_busy", busy, 0);
    check("rst7_in_ready", hs.in_ready, 1);
    check("rst7_round_idx", round_idx, 0);
    check("rst7_round_en", st_round_en, 0);
    check("rst7_perm_cnt", perm_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back('{cnt: 1, lat: 25, hold: 0});
    pulse_load();
    wait_drain("rst7_restart_drain");

    // Unrolled build: four rounds per clock
    @(posedge clk); #1 hs4.in_valid = 1'b1;
    @(negedge clk);
    check("rpc4_st_load", st_load4, 1);
    @(posedge clk); #1 hs4.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rpc4_round_en", st_round_en4, 1);
      check("rpc4_round_idx", round_idx4, idx4_tbl[k]);
    end
    @(negedge clk);
    check("rpc4_out_valid", hs4.out_valid, 1);
    check("rpc4_perm_cnt", perm_cnt4, 1);
    @(negedge clk);
    check("rpc4_valid_drop", hs4.out_valid, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
